renkon_conv_wload: RTL and testbench

- Upstream sequencer for the convolution weight shift register.
- On a start request it streams one FSIZE×FSIZE filter from the weight RAM:
  - issues consecutive read addresses from a base address;
  - aligns the returned data with the RAM read latency;
  - drives read_weight/wreg_we so the wreg captures exactly FSIZE² words.
- Signals completion so the conv controller can start MAC accumulation.

---
 rtl/renkon_conv_wload_pkg.sv | 16 +
 rtl/renkon_wload_delay.sv | 22 ++
 rtl/renkon_conv_wload.sv | 116 +++++++++++
 tb/tb_renkon_conv_wload.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/renkon_conv_wload_pkg.sv
// Shared constants and state encoding for the conv weight-load sequencer.
package renkon_conv_wload_pkg;

  localparam int DWIDTH = 16;              // weight word width, signed
  localparam int WADDR  = 12;              // weight RAM address width
  localparam int FSIZE  = 5;               // filter edge length
  localparam int NTAP   = FSIZE * FSIZE;   // words per filter
  localparam int CWIDTH = $clog2(NTAP);    // issue counter width

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } wload_state_e;

endpackage

// File: rtl/renkon_wload_delay.sv
// DEPTH-deep valid shift pipe; a bit entering at din leaves at dout DEPTH
// cycles later. Synchronous active-low clear drops everything in flight.
module renkon_wload_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic xrst,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] pipe;

  // shift din towards the MSB once per cycle
  always_ff @(posedge clk) begin
    if (!xrst) pipe <= '0;
    else       pipe <= (pipe << 1) | DEPTH'(din);
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/renkon_conv_wload.sv
// Weight-load sequencer: streams one FSIZE x FSIZE filter from the weight RAM
// into the conv weight shift register.
//
// Handshake: req is a start pulse looked at only while idle (busy=0); a req
// seen while busy is dropped, never queued. busy rises the cycle after accept
// and falls the cycle after done. done is a one-cycle pulse coincident with the
// last wreg_we; a new req may be presented in the cycle right after done.
module renkon_conv_wload
  import renkon_conv_wload_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     req,
  input  logic [WADDR-1:0]         base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_re,
  output logic [WADDR-1:0]         mem_addr,
  input  logic signed [DWIDTH-1:0] mem_rdata,
  output logic signed [DWIDTH-1:0] read_weight,
  output logic                     wreg_we,
  output wload_state_e             dbg_state
);

  // DRAIN lasts RD_LAT+1 cycles: the pipe empties, then the final wreg_we.
  localparam int              DCW        = $clog2(RD_LAT + 2);
  localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(NTAP - 1);
  localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(RD_LAT);

  wload_state_e      state, state_nxt;
  logic [WADDR-1:0]  base_q;
  logic [CWIDTH-1:0] cnt;
  logic [DCW-1:0]    dcnt;
  logic              rd_vld;

  // state register
  always_ff @(posedge clk) begin
    if (!xrst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state decode plus the combinational mem_re / done strobes
  always_comb begin
    state_nxt = state;
    mem_re    = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_re = 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (dcnt == DRAIN_LAST) begin
          done      = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // latch base on accept; count issued reads, then drain cycles
  always_ff @(posedge clk) begin
    if (!xrst) begin
      base_q <= '0;
      cnt    <= '0;
      dcnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            base_q <= base_addr;
            cnt    <= '0;
          end
        end
        S_ISSUE: begin
          if (cnt != CNT_LAST) cnt <= cnt + CWIDTH'(1);
          dcnt <= '0;
        end
        S_DRAIN: dcnt <= dcnt + DCW'(1);
        default: ;
      endcase
    end
  end

  // address wraps silently modulo 2^WADDR
  assign mem_addr  = base_q + WADDR'(cnt);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  renkon_wload_delay #(
    .DEPTH (RD_LAT)
  ) u_delay (
    .clk  (clk),
    .xrst (xrst),
    .din  (mem_re),
    .dout (rd_vld)
  );

  // register returned data and raise the shift enable one cycle later
  always_ff @(posedge clk) begin
    if (!xrst) begin
      read_weight <= '0;
      wreg_we     <= 1'b0;
    end else begin
      wreg_we <= rd_vld;
      if (rd_vld) read_weight <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_renkon_conv_wload.sv
// Bench for renkon_conv_wload: one RD_LAT=1 and one RD_LAT=3 instance, each
// with its own RAM latency model, reference model and scoreboard monitor.
module tb_renkon_conv_wload;
  import renkon_conv_wload_pkg::*;

  typedef struct {
    int          c;      // cycle the event must appear in
    logic [15:0] v;      // address (zero-extended) or data word
    logic        last;   // done expected with this wreg_we
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic xrst = 1'b0;
  int   cyc  = 0;

  always #5 clk = ~clk;

  // cycle number of the current clock period
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared state ----------------
  logic        req_v  [2];
  logic [11:0] base_v [2];
  logic [15:0] ram [4096];
  logic [15:0] pat [3] = '{16'h8000, 16'hFFFF, 16'h7FFF};
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- per-instance harness ----------------
  for (genvar g = 0; g < 2; g++) begin : g_d
    localparam int L = (g == 0) ? 1 : 3;

    logic         busy, done, mem_re, wreg_we;
    logic [11:0]  mem_addr;
    logic [15:0]  mem_rdata, read_weight;
    wload_state_e dbg_state;

    renkon_conv_wload #(.RD_LAT(L)) u_dut (
      .clk         (clk),
      .xrst        (xrst),
      .req         (req_v[g]),
      .base_addr   (base_v[g]),
      .busy        (busy),
      .done        (done),
      .mem_re      (mem_re),
      .mem_addr    (mem_addr),
      .mem_rdata   (mem_rdata),
      .read_weight (read_weight),
      .wreg_we     (wreg_we),
      .dbg_state   (dbg_state)
    );

    // RAM with L-cycle read latency
    logic [15:0] rpipe [L];
    always @(posedge clk) begin
      rpipe[0] <= ram[mem_addr];
      for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[L-1];

    // wreg device: new word enters at tap NTAP-1, oldest ends at tap 0
    logic [15:0] wreg [NTAP];
    always @(posedge clk) begin
      if (wreg_we) begin
        for (int i = 0; i < NTAP - 1; i++) wreg[i] <= wreg[i+1];
        wreg[NTAP-1] <= read_weight;
      end
    end

    // reference model: decides acceptance and schedules every expected event
    exp_t addr_q[$];
    exp_t we_q[$];
    int   busy_lo = -1, busy_hi = -2, free_at = 0;
    logic rst_prev = 1'b0;
    always @(posedge clk) begin : model
      logic [11:0] a;
      rst_prev <= !xrst;
      if (!xrst) begin
        addr_q.delete();
        we_q.delete();
        busy_lo = -1;
        busy_hi = -2;
        free_at = 0;
      end else if (req_v[g] && cyc >= free_at) begin
        for (int k = 0; k < NTAP; k++) begin
          a = base_v[g] + 12'(k);
          addr_q.push_back('{cyc + 1 + k, {4'h0, a}, 1'b0});
          we_q.push_back('{cyc + L + 2 + k, ram[a], (k == NTAP - 1)});
        end
        busy_lo = cyc + 1;
        busy_hi = cyc + L + NTAP + 1;
        free_at = cyc + L + NTAP + 2;
      end
    end

    // monitor: compare DUT outputs against the scheduled events
    int we_cnt = 0, done_cnt = 0;
    always @(negedge clk) begin : mon
      exp_t e;
      if (rst_prev) begin
        chk($sformatf("d%0d rst busy", g), busy, 0);
        chk($sformatf("d%0d rst done", g), done, 0);
        chk($sformatf("d%0d rst mem_re", g), mem_re, 0);
        chk($sformatf("d%0d rst mem_addr", g), mem_addr, 0);
        chk($sformatf("d%0d rst read_weight", g), read_weight, 0);
        chk($sformatf("d%0d rst wreg_we", g), wreg_we, 0);
        chk($sformatf("d%0d rst state", g), dbg_state, S_IDLE);
      end else begin
        chk($sformatf("d%0d busy", g), busy, (cyc >= busy_lo && cyc <= busy_hi));
        if (mem_re) begin
          if (addr_q.size() == 0) miss($sformatf("d%0d unexpected mem_re addr=0x%0h", g, mem_addr));
          else begin
            e = addr_q.pop_front();
            chk($sformatf("d%0d mem_re cycle", g), cyc, e.c);
            chk($sformatf("d%0d mem_addr", g), mem_addr, e.v[11:0]);
          end
        end else if (addr_q.size() > 0 && addr_q[0].c <= cyc) begin
          e = addr_q.pop_front();
          miss($sformatf("d%0d missing mem_re for addr 0x%0h", g, e.v[11:0]));
        end
        if (wreg_we) begin
          we_cnt++;
          if (we_q.size() == 0) miss($sformatf("d%0d unexpected wreg_we", g));
          else begin
            e = we_q.pop_front();
            chk($sformatf("d%0d wreg_we cycle", g), cyc, e.c);
            chk($sformatf("d%0d read_weight", g), read_weight, e.v);
            chk($sformatf("d%0d done", g), done, e.last);
          end
        end else begin
          if (done) miss($sformatf("d%0d done without wreg_we", g));
          if (we_q.size() > 0 && we_q[0].c <= cyc) begin
            e = we_q.pop_front();
            miss($sformatf("d%0d missing wreg_we for 0x%0h", g, e.v));
          end
        end
        if (done) done_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // hold req for exactly one cycle, starting in cycle 'at'
  task automatic issue_req(input int g, input logic [11:0] b, input int at, output int c);
    wait_cycle(at);
    req_v[g]  = 1'b1;
    base_v[g] = b;
    c = cyc;
    @(posedge clk);
    #1;
    req_v[g] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c, c2, w0, d0, w1, d1;
    req_v[0] = 1'b0;  req_v[1] = 1'b0;
    base_v[0] = '0;   base_v[1] = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 16'($urandom);
    for (int k = 0; k < NTAP; k++) ram[12'h100 + k] = 16'(k - 12);
    for (int k = 0; k < NTAP; k++) ram[12'h400 + k] = pat[k % 3];

    xrst = 1'b0;
    repeat (3) @(posedge clk);
    #1 xrst = 1'b1;

    // basic load, RD_LAT=1
    w0 = g_d[0].we_cnt; d0 = g_d[0].done_cnt;
    issue_req(0, 12'h100, cyc + 1, c);
    wait_cycle(c + 29);
    chk("t1 tap0", g_d[0].wreg[0], 16'hFFF4);
    chk("t1 tap12", g_d[0].wreg[12], 16'h0000);
    chk("t1 tap24", g_d[0].wreg[24], 16'h000C);
    chk("t1 we count", g_d[0].we_cnt - w0, NTAP);
    chk("t1 done count", g_d[0].done_cnt - d0, 1);

    // address wrap
    w0 = g_d[0].we_cnt;
    issue_req(0, 12'hFF0, cyc + 2, c);
    wait_cycle(c + 30);
    chk("t2 we count", g_d[0].we_cnt - w0, NTAP);
    chk("t2 tap0", g_d[0].wreg[0], ram[12'hFF0]);
    chk("t2 tap24", g_d[0].wreg[24], ram[12'h008]);

    // req while busy is dropped
    w0 = g_d[0].we_cnt; d0 = g_d[0].done_cnt;
    issue_req(0, 12'h180, cyc + 2, c);
    issue_req(0, 12'h200, c + 10, c2);
    wait_cycle(c + 30);
    chk("t3 we count", g_d[0].we_cnt - w0, NTAP);
    chk("t3 done count", g_d[0].done_cnt - d0, 1);

    // back-to-back: req in done cycle ignored, next cycle accepted
    w0 = g_d[0].we_cnt; d0 = g_d[0].done_cnt;
    issue_req(0, 12'h300, cyc + 2, c);
    issue_req(0, 12'h500, c + 27, c2);
    issue_req(0, 12'h600, c + 28, c2);
    wait_cycle(c + 60);
    chk("t4 we count", g_d[0].we_cnt - w0, 2 * NTAP);
    chk("t4 done count", g_d[0].done_cnt - d0, 2);

    // reset mid-operation, then a fresh load
    d0 = g_d[0].done_cnt;
    issue_req(0, 12'h100, cyc + 2, c);
    wait_cycle(c + 15);
    xrst = 1'b0;
    @(posedge clk);
    #1 xrst = 1'b1;
    wait_cycle(c + 35);
    chk("t5 no done after reset", g_d[0].done_cnt - d0, 0);
    issue_req(0, 12'h100, cyc + 1, c);
    wait_cycle(c + 29);
    chk("t5 reload done count", g_d[0].done_cnt - d0, 1);
    chk("t5 reload tap0", g_d[0].wreg[0], 16'hFFF4);

    // RD_LAT=3, extreme signed data
    w1 = g_d[1].we_cnt; d1 = g_d[1].done_cnt;
    issue_req(1, 12'h400, cyc + 2, c);
    wait_cycle(c + 31);
    chk("t6 we count", g_d[1].we_cnt - w1, NTAP);
    chk("t6 done count", g_d[1].done_cnt - d1, 1);
    chk("t6 tap0", g_d[1].wreg[0], 16'h8000);
    chk("t6 tap1", g_d[1].wreg[1], 16'hFFFF);
    chk("t6 tap2", g_d[1].wreg[2], 16'h7FFF);
    chk("t6 tap24", g_d[1].wreg[24], 16'h8000);

    // random requests on both instances at random spacing
    for (int n = 0; n < 16; n++) begin
      issue_req($urandom_range(0, 1), 12'($urandom), cyc + $urandom_range(1, 35), c);
    end
    wait_cycle(cyc + 40);
    chk("d0 addr_q drained", g_d[0].addr_q.size(), 0);
    chk("d0 we_q drained", g_d[0].we_q.size(), 0);
    chk("d1 addr_q drained", g_d[1].addr_q.size(), 0);
    chk("d1 we_q drained", g_d[1].we_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
